// File: rtl/main_memory_bram_reader.sv
// ---------------------------------------------------------------------------
// main_memory_bram_reader
//   Read-side controller for the main memory block RAM. A start command
//   captures a base address and a length. The block then streams that many
//   words out of the RAM onto a valid/ready stream. It handles the RAM's
//   one-cycle registered-address read latency and supports full backpressure.
//
// Ports
//   i_bram_rd_clk / i_bram_rd_rst_n  read clock, async active-low reset
//   i_rd_start, i_rd_base_addr,      burst command (sampled in IDLE only)
//   i_rd_len
//   i_rd_abort                       synchronous abort, flushes everything
//   o_bram_rd_addr, i_bram_rd_data   RAM read port (data valid one cycle
//                                    after the address)
//   o_rd_data, o_rd_valid,           output stream
//   o_rd_last, i_rd_ready
//   o_rd_busy, o_rd_done             burst status
// ---------------------------------------------------------------------------
module main_memory_bram_reader #(
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int LEN_WIDTH       = BRAM_ADDR_WIDTH + 1
) (
  input  logic                       i_bram_rd_clk,
  input  logic                       i_bram_rd_rst_n,
  input  logic                       i_rd_start,
  input  logic                       i_rd_abort,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_rd_base_addr,
  input  logic [LEN_WIDTH-1:0]       i_rd_len,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] i_bram_rd_data,
  output logic [BRAM_DATA_WIDTH-1:0] o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_rd_last,
  input  logic                       i_rd_ready,
  output logic                       o_rd_busy,
  output logic                       o_rd_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic                       last;
    logic [BRAM_DATA_WIDTH-1:0] data;
  } word_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;

  // Read issued last cycle; its data is on i_bram_rd_data this cycle.
  logic in_flight;
  logic in_flight_last;

  // 2-entry output FIFO
  word_t      fifo [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] occ;

  logic       pop;
  logic       push;
  logic [2:0] pending;
  logic       issue;
  logic       drain_empty;

  assign pop  = (occ != 2'd0) && i_rd_ready;
  assign push = in_flight;

  // Words that will occupy the FIFO once everything in flight has landed,
  // net of this cycle's pop. Keeping this below 2 before each issue means the
  // FIFO can never overflow. A steady ready=1 still gives one word per cycle.
  assign pending = {1'b0, occ} + {2'b0, in_flight} - {2'b0, pop};
  assign issue   = (state == READ) && (remaining != '0) && (pending < 3'd2);

  // The burst is finished when nothing is in flight and this cycle's pop
  // (if any) takes the final buffered word.
  assign drain_empty = !in_flight && (occ == {1'b0, pop});

  assign o_rd_valid = (occ != 2'd0);
  assign o_rd_data  = fifo[rd_ptr].data;
  assign o_rd_last  = fifo[rd_ptr].last && o_rd_valid;

  always_ff @(posedge i_bram_rd_clk or negedge i_bram_rd_rst_n) begin
    if (!i_bram_rd_rst_n) begin
      state          <= IDLE;
      remaining      <= '0;
      o_bram_rd_addr <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      occ            <= 2'd0;
      o_rd_busy      <= 1'b0;
      o_rd_done      <= 1'b0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else if (i_rd_abort) begin
      // Drop the buffered words and the read in flight. The address is held.
      state          <= IDLE;
      remaining      <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      occ            <= 2'd0;
      o_rd_busy      <= 1'b0;
      o_rd_done      <= 1'b0;
    end else begin
      o_rd_done      <= 1'b0;
      in_flight      <= issue;
      in_flight_last <= issue && (remaining == LEN_WIDTH'(1));

      if (push) begin
        fifo[wr_ptr] <= '{last: in_flight_last, data: i_bram_rd_data};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (i_rd_start) begin
            o_bram_rd_addr <= i_rd_base_addr;
            remaining      <= i_rd_len;
            if (i_rd_len == '0) begin
              o_rd_done <= 1'b1;
            end else begin
              o_rd_busy <= 1'b1;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            // The RAM has no read enable. Holding the address between issues
            // only repeats a read that nobody captures.
            o_bram_rd_addr <= o_bram_rd_addr + 1'b1;
            remaining      <= remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            o_rd_done <= 1'b1;
            o_rd_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_bram_reader.sv
module tb_main_memory_bram_reader;
  localparam int DW = 16;
  localparam int AW = 15;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_rd_start, i_rd_abort, i_rd_ready;
  logic [AW-1:0] i_rd_base_addr;
  logic [LW-1:0] i_rd_len;
  logic [AW-1:0] o_bram_rd_addr;
  logic [DW-1:0] i_bram_rd_data;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid, o_rd_last, o_rd_busy, o_rd_done;

  main_memory_bram_reader #(.BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_bram_rd_clk  (clk),
    .i_bram_rd_rst_n(rst_n),
    .i_rd_start     (i_rd_start),
    .i_rd_abort     (i_rd_abort),
    .i_rd_base_addr (i_rd_base_addr),
    .i_rd_len       (i_rd_len),
    .o_bram_rd_addr (o_bram_rd_addr),
    .i_bram_rd_data (i_bram_rd_data),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_rd_last      (o_rd_last),
    .i_rd_ready     (i_rd_ready),
    .o_rd_busy      (o_rd_busy),
    .o_rd_done      (o_rd_done)
  );

  always #5 clk = ~clk;

  // RAM contents as a pure function of the address
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a, 1'b1} ^ {a[3:0], a[14:3]};
  endfunction

  // Registered-address RAM model
  always @(posedge clk) i_bram_rd_data <= memf(o_bram_rd_addr);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_pop  = 0;
  int   n_last = 0;
  int   n_done = 0;

  // Scoreboard monitor: compares every handshake and checks that the
  // stream holds steady while it is stalled.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== prev_data || o_rd_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                   o_rd_valid, o_rd_data, o_rd_last, prev_data, prev_last);
        end
      end
      if (o_rd_valid && i_rd_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got d=%h l=%b, required no word", o_rd_data, o_rd_last);
        end else begin
          e = sb.pop_front();
          if (o_rd_data !== e.data || o_rd_last !== e.last) begin
            errors++;
            $display("FAIL stream_word: got d=%h l=%b, required d=%h l=%b",
                     o_rd_data, o_rd_last, e.data, e.last);
          end
        end
        n_pop++;
        if (o_rd_last) n_last++;
      end
      if (o_rd_done) n_done++;
      prev_stall = o_rd_valid && !i_rd_ready;
      prev_data  = o_rd_data;
      prev_last  = o_rd_last;
    end
  end

  // Caller is just after a rising edge (cycle 0); returns just after the
  // next edge (cycle 1).
  task automatic start_burst(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] a;
    i_rd_start     = 1'b1;
    i_rd_base_addr = base;
    i_rd_len       = LW'(len);
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      sb.push_back('{last: (i == len - 1), data: memf(a)});
    end
    @(posedge clk); #1;
    i_rd_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (n_done > d0) begin ok = 1'b1; return; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({o_bram_rd_addr, o_rd_data, o_rd_valid, o_rd_last, o_rd_busy, o_rd_done} !== '0) begin
      errors++;
      $display("FAIL reset_values: got addr=%h d=%h v=%b l=%b b=%b dn=%b, required all 0",
               o_bram_rd_addr, o_rd_data, o_rd_valid, o_rd_last, o_rd_busy, o_rd_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [AW-1:0] ea;
    start_burst(AW'('h10), 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        ea = AW'('h10 + k - 1);
        checks++;
        if (o_bram_rd_addr !== ea) begin
          errors++;
          $display("FAIL basic_addr c%0d: got %h, required %h", k, o_bram_rd_addr, ea);
        end
      end
      checks++;
      if (o_rd_valid !== (k >= 3 && k <= 6)) begin
        errors++;
        $display("FAIL basic_valid c%0d: got %b, required %b", k, o_rd_valid, (k >= 3 && k <= 6));
      end
      checks++;
      if (o_rd_last !== (k == 6)) begin
        errors++;
        $display("FAIL basic_last c%0d: got %b, required %b", k, o_rd_last, (k == 6));
      end
      checks++;
      if (o_rd_done !== (k == 7)) begin
        errors++;
        $display("FAIL basic_done c%0d: got %b, required %b", k, o_rd_done, (k == 7));
      end
      checks++;
      if (o_rd_busy !== (k <= 6)) begin
        errors++;
        $display("FAIL basic_busy c%0d: got %b, required %b", k, o_rd_busy, (k <= 6));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_drained: got %0d words left, required 0", sb.size());
    end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] ea;
    bit ok;
    int d0 = n_done;
    start_burst(AW'('h7FFE), 4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ea = AW'('h7FFE) + AW'(k - 1);
      checks++;
      if (o_bram_rd_addr !== ea) begin
        errors++;
        $display("FAIL wrap_addr c%0d: got %h, required %h", k, o_bram_rd_addr, ea);
      end
      @(posedge clk); #1;
    end
    wait_done(d0, 50, ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_done: got done=%b left=%0d, required done=1 left=0", ok, sb.size());
    end
  endtask

  task automatic test_backpressure;
    logic [AW-1:0] issued;
    int p0 = n_pop, l0 = n_last, d0 = n_done;
    bit ok = 1'b0;
    start_burst(AW'('h100), 16);
    for (int cyc = 1; cyc < 300; cyc++) begin
      // Reads issued minus words taken = FIFO occupancy + read in flight
      issued = o_bram_rd_addr - AW'('h100);
      checks++;
      if (int'(issued) - (n_pop - p0) > 2) begin
        errors++;
        $display("FAIL bp_outstanding c%0d: got %0d, required <=2", cyc, int'(issued) - (n_pop - p0));
      end
      if (n_done > d0) begin ok = 1'b1; break; end
      if (cyc < 5)       i_rd_ready = 1'b1;
      else if (cyc < 10) i_rd_ready = 1'b0;
      else               i_rd_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    i_rd_ready = 1'b1;
    checks++;
    if (!ok || n_pop - p0 != 16 || n_last - l0 != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_burst: got done=%b words=%0d lasts=%0d left=%0d, required 1/16/1/0",
               ok, n_pop - p0, n_last - l0, sb.size());
    end
  endtask

  task automatic test_zero_len;
    int p0 = n_pop;
    start_burst(AW'('h20), 0);
    @(negedge clk);
    checks++;
    if (o_rd_done !== 1'b1 || o_rd_busy !== 1'b0 || o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got dn=%b b=%b v=%b, required 1/0/0", o_rd_done, o_rd_busy, o_rd_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o_rd_done !== 1'b0 || n_pop != p0) begin
      errors++;
      $display("FAIL zero_len_after: got dn=%b words=%0d, required 0/0", o_rd_done, n_pop - p0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy;
    int p0 = n_pop, d0 = n_done;
    bit ok;
    start_burst(AW'('h200), 8);
    repeat (3) begin @(posedge clk); #1; end
    i_rd_start = 1'b1; i_rd_base_addr = AW'('h300); i_rd_len = LW'(3);
    @(posedge clk); #1;
    i_rd_start = 1'b0;
    wait_done(d0, 100, ok);
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (!ok || n_pop - p0 != 8 || sb.size() != 0 || o_rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: got done=%b words=%0d left=%0d busy=%b, required 1/8/0/0",
               ok, n_pop - p0, sb.size(), o_rd_busy);
    end
  endtask

  task automatic test_abort;
    int p0 = n_pop, d0;
    bit ok, hit = 1'b0;
    start_burst(AW'('h0400), 10);
    for (int i = 0; i < 50; i++) begin
      if (n_pop - p0 >= 3) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach3: got %0d words, required 3", n_pop - p0);
    end
    d0 = n_done;
    i_rd_abort = 1'b1;
    @(posedge clk); #1;
    i_rd_abort = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (o_rd_valid !== 1'b0 || o_rd_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_flush: got v=%b b=%b, required 0/0", o_rd_valid, o_rd_busy);
    end
    // start together with abort must be ignored
    @(posedge clk); #1;
    i_rd_abort = 1'b1; i_rd_start = 1'b1; i_rd_base_addr = AW'('h50); i_rd_len = LW'(3);
    @(posedge clk); #1;
    i_rd_abort = 1'b0; i_rd_start = 1'b0;
    p0 = n_pop;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (n_done != d0 || o_rd_busy !== 1'b0 || n_pop != p0) begin
      errors++;
      $display("FAIL abort_quiet: got dones=%0d busy=%b words=%0d, required 0/0/0",
               n_done - d0, o_rd_busy, n_pop - p0);
    end
    start_burst(AW'('h0), 2);
    wait_done(d0, 50, ok);
    checks++;
    if (!ok || n_pop - p0 != 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL abort_recover: got done=%b words=%0d left=%0d, required 1/2/0",
               ok, n_pop - p0, sb.size());
    end
  endtask

  task automatic test_reset_mid_burst;
    int d0 = n_done;
    start_burst(AW'('h40), 10);
    repeat (4) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_bram_rd_addr, o_rd_data, o_rd_valid, o_rd_last, o_rd_busy, o_rd_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got addr=%h d=%h v=%b l=%b b=%b dn=%b, required all 0",
               o_bram_rd_addr, o_rd_data, o_rd_valid, o_rd_last, o_rd_busy, o_rd_done);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (o_bram_rd_addr !== '0 || o_rd_busy !== 1'b0 || o_rd_valid !== 1'b0 || n_done != d0) begin
      errors++;
      $display("FAIL reset_release: got addr=%h b=%b v=%b dones=%0d, required 0/0/0/0",
               o_bram_rd_addr, o_rd_busy, o_rd_valid, n_done - d0);
    end
  endtask

  initial begin
    i_rd_start = 1'b0; i_rd_abort = 1'b0; i_rd_ready = 1'b1;
    i_rd_base_addr = '0; i_rd_len = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_while_busy();
    test_abort();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/main_memory_bram_reader.md
Name: main_memory_bram_reader

Overview:
- Read-side controller for the main memory block RAM.
- On a start command, streams a burst of words from a base address and handles the RAM's one-cycle registered-address read latency.
- Presents the words on a valid/ready stream with full backpressure support.
- Sits between the block RAM read port and the main memory read mux, in the RAM read-clock domain.

Parameters:
- BRAM_DATA_WIDTH, 16, RAM data port width.
- BRAM_ADDR_WIDTH, 15, RAM address port width; depth is 2**BRAM_ADDR_WIDTH.
- LEN_WIDTH, BRAM_ADDR_WIDTH+1, burst length counter width; allows a full-memory burst.

Ports:
- i_bram_rd_clk  in  1  read clock; the only clock.
- i_bram_rd_rst_n  in  1  reset, asynchronous, active-low.
- i_rd_start  in  1  start pulse; sampled only in IDLE.
- i_rd_abort  in  1  synchronous abort; highest priority after reset.
- i_rd_base_addr  in  BRAM_ADDR_WIDTH  first word address, captured with start.
- i_rd_len  in  LEN_WIDTH  words to read, captured with start; 0 is legal.
- o_bram_rd_addr  out  BRAM_ADDR_WIDTH  address to the RAM read port.
- i_bram_rd_data  in  BRAM_DATA_WIDTH  RAM read data; valid the cycle after the address is presented.
- o_rd_data  out  BRAM_DATA_WIDTH  stream data.
- o_rd_valid  out  1  stream valid.
- o_rd_last  out  1  final word of the burst; qualified by o_rd_valid.
- i_rd_ready  in  1  stream ready from downstream.
- o_rd_busy  out  1  high from the cycle after start until done.
- o_rd_done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty, no reads in flight.
- FSM states: IDLE, READ, DRAIN.
  - IDLE: on i_rd_start=1, capture base and len, set busy. If len=0, pulse o_rd_done the next cycle, leave busy low and stay IDLE. Otherwise go to READ.
  - READ: issue reads while remaining>0. After the last issue, go to DRAIN.
  - DRAIN: wait until no read is in flight and the buffer is empty, then pulse o_rd_done, drop busy and return to IDLE in the same cycle.
- Issue:
  - A read is "issued" in cycle N when the issue condition holds and o_bram_rd_addr carries the next address.
  - The word is captured from i_bram_rd_data at the end of cycle N+1 into a 2-entry output FIFO.
  - Issue condition: (occupancy + in_flight − pop_this_cycle) < 2. This guarantees no overflow and still gives 1 word/cycle when i_rd_ready is held high.
- Address:
  - Increments by 1 per issue and wraps modulo 2**BRAM_ADDR_WIDTH.
  - o_bram_rd_addr holds its value when not issuing; the RAM has no read enable, so unissued data is ignored.
- Latency: start sampled at the end of cycle 0 → base address presented in cycle 1 → first o_rd_valid in cycle 3.
- Stream rules:
  - o_rd_data and o_rd_last hold stable while o_rd_valid=1 and i_rd_ready=0.
  - Words are never dropped or duplicated, and order is preserved.
  - o_rd_last is 1 on exactly the len-th word.
- Done: o_rd_done pulses in the cycle after the last-word handshake.
- i_rd_start while busy is ignored.
- i_rd_abort=1 in any state, sampled at a clock edge:
  - next cycle: IDLE, buffer flushed, in-flight discarded, o_rd_valid/o_rd_busy = 0, no o_rd_done.
  - i_rd_start in the same cycle as i_rd_abort is ignored.
- Asynchronous reset mid-burst forces the reset values immediately, with no done pulse.

Test Plan:
- Reset: assert i_bram_rd_rst_n=0 mid-burst → all outputs 0 immediately; after release, o_bram_rd_addr=0 and the block is IDLE.
- Basic burst: base=0x0010, len=4, i_rd_ready=1 → addr 0x10..0x13 in cycles 1–4; o_rd_valid in cycles 3–6 with mem[0x10..0x13]; o_rd_last in cycle 6; o_rd_done in cycle 7.
- Wrap: base=0x7FFE, len=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; data order matches.
- Backpressure: len=16 with i_rd_ready low for 5 cycles mid-burst and randomly toggled → in-flight+occupancy never exceeds 2; o_rd_data stable while stalled; all 16 words in order, exactly one o_rd_last.
- Zero length and start while busy: len=0 → o_rd_done the next cycle, no o_rd_valid. A second i_rd_start during a len=8 burst → ignored, exactly 8 words delivered.
- Abort: i_rd_abort after the 3rd handshake of len=10 → o_rd_valid=0 the next cycle, no o_rd_done. A new burst from base=0x0 len=2 afterwards returns mem[0], mem[1].
